// File: rtl/serial_deser_pkg.sv
// ============================================================================
// Module      : serial_deser_pkg
// Description : Shared types, defaults and frame-length helper for serial_deser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_deser_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int DESER_WIDTH_DEF = 8;

    // One extra bit per frame when an even-parity bit trails the data.
    function automatic int frame_len(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_core.sv
// ============================================================================
// Module      : sipo_shift_core
// Description : Serial-in shift register, bit counter and frame-done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shift_core
    import serial_deser_pkg::*;
#(
    parameter int WIDTH     = DESER_WIDTH_DEF,
    parameter int MSB_FIRST = 1,
    parameter bit PARITY_EN = 1'b0,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] word,
    output logic             frame_done,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int              FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             data_bit;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_next = {shift_reg[WIDTH-2:0], d_in};
        end else begin : g_lsb_first
            assign shift_next = {d_in, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    // With parity the last bit of a frame is not data: the word is already
    // complete in the register and the current bit must not be shifted in.
    generate
        if (PARITY_EN) begin : g_parity
            assign data_bit = (bit_cnt != LAST_CNT);
            assign word     = shift_reg;
        end else begin : g_no_parity
            assign data_bit = 1'b1;
            assign word     = shift_next;
        end
    endgenerate

    assign frame_done = bit_en && (bit_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (bit_en) begin
            if (data_bit) begin
                shift_reg <= shift_next;
            end
            bit_cnt <= frame_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_deser.sv
// ============================================================================
// Module      : serial_deser
// Description : Serial-to-parallel deserializer with valid/ready output and
//               sticky overrun flag. Optional parity check: SERIAL_DESER_PARITY_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH     = DESER_WIDTH_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         d_in,
    input  logic                         bit_en,
    input  logic                         ready_in,
    input  logic                         clr_ovr_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         valid_out,
    output logic                         overrun_out,
`ifdef SERIAL_DESER_PARITY_CHK_EN
    output logic                         par_err_out,
`endif
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt_out
);

`ifdef SERIAL_DESER_PARITY_CHK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] word;
    logic             frame_done;
    state_t           state;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .PARITY_EN (PARITY_EN),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_in       (d_in),
        .bit_en     (bit_en),
        .word       (word),
        .frame_done (frame_done),
        .bit_cnt    (bit_cnt_out)
    );

`ifdef SERIAL_DESER_PARITY_CHK_EN
    // On the completing edge d_in carries the parity bit itself.
    logic par_calc;
    assign par_calc = (^word) ^ d_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_out <= 1'b0;
        end else if (frame_done && ((state == S_IDLE) || ready_in)) begin
            par_err_out <= par_calc;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            data_out    <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            if (clr_ovr_in) begin
                overrun_out <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (frame_done) begin
                        data_out  <= word;
                        valid_out <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ready_in) begin
                        if (frame_done) begin
                            data_out <= word;
                        end else begin
                            valid_out <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end else if (frame_done) begin
                        // Placed after the clear so a same-edge overrun wins.
                        overrun_out <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/serial_deser.md
Name: serial_deser

Overview:
Serial-to-parallel deserializer. It sits directly downstream of the team's D flip-flop stage and consumes its registered serial output (q_out) as its d_in. It assembles WIDTH qualified bits into a word and presents the word on a valid/ready output port. It detects and flags words lost to downstream backpressure.

Parameters:
WIDTH, 8, data bits per word; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
clk  input  1  single rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
d_in  input  1  serial bit, driven from the upstream flip-flop's q_out.
bit_en  input  1  d_in is sampled on a rising edge only when bit_en=1.
ready_in  input  1  downstream accepts the word this cycle.
clr_ovr_in  input  1  synchronous clear of overrun_out.
data_out  output  WIDTH  assembled word; stable while valid_out=1.
valid_out  output  1  data_out holds an unconsumed word.
overrun_out  output  1  sticky flag: a completed word was dropped.
bit_cnt_out  output  $clog2(WIDTH+1)  bits captured in the current frame.

Behaviour:
- Reset (async assert, sync release): shift register=0, bit counter=0, data_out=0, valid_out=0, overrun_out=0, FSM=S_IDLE. Any partial word is discarded.
- Shift: on an edge with bit_en=1, d_in is shifted in and the counter increments. With bit_en=0 the shift register and counter hold.
- Frame completion: an edge with bit_en=1 and counter=WIDTH-1. At that edge the counter wraps to 0, and the full word (including the current bit) is the candidate for the output register.
- Latency: valid_out rises on the same edge that samples the last bit, so it is visible the following cycle.
- Output FSM:
  - S_IDLE (valid_out=0): on frame completion, load data_out, set valid_out=1, go to S_HOLD.
  - S_HOLD (valid_out=1): data_out is frozen. An edge with ready_in=1 is a transfer.
    - Transfer with no completion: valid_out=0, go to S_IDLE.
    - Transfer and completion on the same edge: load the new word, valid_out stays 1, stay in S_HOLD.
    - Completion without transfer: the new word is dropped, overrun_out is set, the held word is unchanged.
- overrun_out: cleared by reset or clr_ovr_in=1. If clr_ovr_in=1 and a new overrun occur on the same edge, the set wins.
- bit_cnt_out mirrors the internal counter: 0..WIDTH-1, or 0..WIDTH under the optional feature.
- ready_in is ignored in S_IDLE. Back-to-back words with bit_en held high every cycle sustain full throughput when ready_in=1.

Optional Feature:
Macro SERIAL_DESER_PARITY_CHK_EN.
- With the macro defined:
  - A frame is WIDTH data bits followed by one even-parity bit.
  - The counter runs 0..WIDTH and completion occurs on the parity bit.
  - Extra output par_err_out (1 bit) loads together with data_out; it is 1 when the XOR of the data bits and the parity bit is 1.
  - par_err_out is reset to 0 and held with data_out. The word is still delivered.
- Without the macro: no parity bit, no par_err_out port, and frame length is WIDTH.

Decomposition:
- Package serial_deser_pkg holds:
  - the state typedef (S_IDLE, S_HOLD);
  - the constant DESER_WIDTH_DEF=8;
  - a frame-length function returning WIDTH, or WIDTH+1 with parity.
- Sub-module sipo_shift_core holds the shift register, bit counter, completion pulse and MSB_FIRST ordering.
- The top level holds the output register, FSM, overrun logic and parity check.

Test Plan:
- WIDTH=8, MSB_FIRST=1, ready_in=1, bit_en=1 every cycle, bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5 and valid_out high for exactly 1 cycle, one cycle after the 8th sampling edge.
- Upstream flip-flop pattern: d_in toggling every clock starting at 0, bit_en=1, ready_in=1 -> a continuous stream of 8'h55 words, one every 8 cycles, overrun_out=0. With MSB_FIRST=0 -> 8'hAA.
- Backpressure: ready_in=0 through two frame completions -> data_out holds the first word, overrun_out=1 from the second completion. After ready_in=1 for one cycle the first word transfers and valid_out=0. clr_ovr_in pulse -> overrun_out=0.
- bit_en gaps: the same 8'hA5 bits with bit_en=0 for 3 cycles between each bit -> bit_cnt_out freezes during gaps and the result is 8'hA5.
- Reset mid-frame: assert reset_n=0 asynchronously after 5 bits -> all outputs 0 immediately. After release, 8 fresh bits 1,1,0,0,1,1,0,0 -> 8'hCC with no residue.
- With SERIAL_DESER_PARITY_CHK_EN: 8'hA5 followed by parity bit 1 -> par_err_out=1 with valid_out. Parity bit 0 -> par_err_out=0.
